vocab_reader: RTL
=================

# vocab_reader

Index-to-word lookup engine for the tokenizer path: given a token index, it walks the null-terminated vocabulary SRAM (words packed back to back, each ending in 0x00, vocabulary ending with an empty word, i.e. a double 0x00) to the idx-th word. It streams that word out byte by byte, including its 0x00 terminator, over a valid/ready interface. It is the inverse of the word matcher (word -> hit), and its output stream has exactly the null-terminated format the matcher's input word RAM expects.

## Interface
- ADDR_WIDTH, 4, vocab SRAM address width (2^ADDR_WIDTH bytes)
- DATA_WIDTH, 8, byte width; 0 is the terminator
- IDX_WIDTH, 4, token index width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- idx  in  IDX_WIDTH  token index (0 = first word), latched with start
- busy  out  1  high in every state except IDLE
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_WIDTH  SRAM address (registered)
- mem_rdata  in  DATA_WIDTH  SRAM data, valid the cycle after mem_rd_en
- out_valid  out  1  stream byte valid
- out_data  out  DATA_WIDTH  stream byte
- out_last  out  1  high with the 0x00 terminator beat
- out_ready  in  1  downstream accept
- done  out  1  one-cycle pulse at end of request
- found  out  1  result; held until next accepted start
- word_addr  out  ADDR_WIDTH  start address of located word; held like found

## Operation
- Internal state: av (ADDR_WIDTH), cnt (IDX_WIDTH), target (IDX_WIDTH), at_start (1 = av is a word's first byte), byte register.
- IDLE: if start, then target<=idx, av<=0, cnt<=0, at_start<=1, found<=0, word_addr<=0, -> SEEK_RD.
- SEEK_RD: mem_rd_en=1, mem_addr=av -> SEEK_EV.
- SEEK_EV (byte b = mem_rdata):
  - at_start && b==0: end of vocab -> DONE, found=0.
  - cnt==target && at_start: word_addr<=av, byte<=b -> EMIT.
  - cnt==target && !at_start: byte<=b -> EMIT (continuation byte, entered from EMIT via SEEK_RD).
  - Otherwise: on b==0, cnt<=cnt+1 and at_start<=1, else at_start<=0; av<=av+1 -> SEEK_RD.
  - If av==2^ADDR_WIDTH-1 and not entering EMIT: DONE, found=0 (no wrap).
- EMIT: out_valid=1, out_data=byte, out_last=(byte==0); all held stable while out_ready=0.
  - Accept with out_last: found<=1 -> DONE.
  - Accept, not last, av==max: truncated word -> DONE, found=0; no out_last beat is issued.
  - Accept, not last, otherwise: av<=av+1, at_start<=0 -> SEEK_RD.
- DONE: done=1 for exactly one cycle -> IDLE. found and word_addr stay valid until the next accepted start.
- A start outside IDLE is ignored; idx is not re-sampled mid-request.
- Asynchronous reset mid-request aborts immediately and drops any stream beat in flight; downstream must discard a partial word.

## Timing
- Reset values: busy 0, mem_rd_en 0, mem_addr 0, out_valid 0, out_data 0, out_last 0, done 0, found 0, word_addr 0; state IDLE.
- Each byte visit costs 2 cycles (RD, EV), with no pipelining of reads.
- Start accepted at edge 0; first out_valid at edge 2*(word_addr+1)+1.
- With out_ready held high, one beat every 3 cycles (EMIT, RD, EV).
- done is asserted the cycle after the out_last beat is accepted.
- busy falls the cycle after done; a new start is accepted in that IDLE cycle.
- Not-found: done is asserted the cycle after the terminating SEEK_EV.
- out_valid never drops before the beat is accepted.

## Test plan
- Vocab "ab\0cd\0\0", idx=1, ready=1 -> first out_valid at edge 9 with 'c'; then 'd', then 0x00 with out_last; done pulse; found=1, word_addr=3.
- Same vocab, idx=0 -> 'a' at edge 3, 'b', 0x00 with out_last; found=1, word_addr=0.
- Same vocab, idx=2 (hits the empty terminator word) -> no out_valid, done pulse, found=0.
- idx=1 with out_ready toggling 0/1 every cycle -> out_data/out_last stable while stalled; exact byte sequence 'c','d',0x00; no duplicates or drops.
- 16-byte vocab with no 0x00, idx=0 -> 16 beats without out_last, then done with found=0; start pulsed mid-stream is ignored.
- rst_n asserted during the second beat -> all outputs return to reset values asynchronously; a fresh start with idx=0 completes normally.

Source files
------------

// File: rtl/vocab_reader.sv
// vocab_reader: token index -> word lookup over a null-terminated vocabulary SRAM.
// Walks the packed word list (each word ends in 0x00; an empty word ends the
// vocabulary) to the idx-th word and streams it, including its 0x00 terminator,
// over a valid/ready interface.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, idx          request and token index; sampled only when idle
//   busy                high whenever a request is in progress
//   mem_rd_en, mem_addr SRAM read strobe and registered address
//   mem_rdata           SRAM data, valid the cycle after mem_rd_en
//   out_valid/out_data/out_last/out_ready  byte stream; out_last marks the 0x00 beat
//   done                one-cycle pulse at the end of a request
//   found, word_addr    result and start address of the word; held until next start
module vocab_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] word_addr
);

  typedef enum logic [2:0] {IDLE, SEEK_RD, SEEK_EV, EMIT, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] AV_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] AV_ONE  = ADDR_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0]  CNT_ONE = IDX_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   av_q, av_d;
  logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]    target_q, target_d;
  logic                    at_start_q, at_start_d;
  logic [DATA_WIDTH-1:0]   byte_q, byte_d;
  logic                    found_q, found_d;
  logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      av_q        <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      at_start_q  <= 1'b0;
      byte_q      <= '0;
      found_q     <= 1'b0;
      word_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      av_q        <= av_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      at_start_q  <= at_start_d;
      byte_q      <= byte_d;
      found_q     <= found_d;
      word_addr_q <= word_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    av_d        = av_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    at_start_d  = at_start_q;
    byte_d      = byte_q;
    found_d     = found_q;
    word_addr_d = word_addr_q;
    busy        = (state_q != IDLE);
    mem_rd_en   = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d    = idx;
          av_d        = '0;
          cnt_d       = '0;
          at_start_d  = 1'b1;
          found_d     = 1'b0;
          word_addr_d = '0;
          state_d     = SEEK_RD;
        end
      end
      SEEK_RD: begin
        mem_rd_en = 1'b1;
        state_d   = SEEK_EV;
      end
      SEEK_EV: begin
        // An empty word at a word boundary ends the vocabulary, even when it
        // is the requested index.
        if (at_start_q && (mem_rdata == '0)) begin
          state_d = DONE;
        end else if (cnt_q == target_q) begin
          if (at_start_q) word_addr_d = av_q;
          byte_d  = mem_rdata;
          state_d = EMIT;
        end else if (av_q == AV_MAX) begin
          state_d = DONE;
        end else begin
          if (mem_rdata == '0) begin
            cnt_d      = cnt_q + CNT_ONE;
            at_start_d = 1'b1;
          end else begin
            at_start_d = 1'b0;
          end
          av_d    = av_q + AV_ONE;
          state_d = SEEK_RD;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (byte_q == '0);
        if (out_ready) begin
          if (byte_q == '0) begin
            found_d = 1'b1;
            state_d = DONE;
          end else if (av_q == AV_MAX) begin
            // Word runs off the end of the SRAM: stop without a last beat.
            state_d = DONE;
          end else begin
            av_d       = av_q + AV_ONE;
            at_start_d = 1'b0;
            state_d    = SEEK_RD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = av_q;
  assign out_data  = byte_q;
  assign found     = found_q;
  assign word_addr = word_addr_q;

endmodule
